// File: rtl/rf_pkg.sv
// =============================================================================
//  Module   : rf_pkg
//  Brief    : Shared constants and types for the MIPS register file slice.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned REG_ZERO  = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_busy_table.sv
// =============================================================================
//  Module   : rf_busy_table
//  Brief    : Per-register busy bits with flush > claim > release priority,
//             plus a registered OR of the whole table.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module rf_busy_table
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 claim_en_i,
  input  logic [ADDR_W-1:0]    claim_addr_i,
  input  logic                 rel_en_i,
  input  logic [ADDR_W-1:0]    rel_addr_i,
  input  logic                 flush_i,
  output logic [2**ADDR_W-1:0] busy_o,
  output logic                 any_busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             any_busy_q;

  // Claim is applied after release so a same-cycle claim/write leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (rel_en_i)   busy_d[rel_addr_i]   = 1'b0;
      if (claim_en_i) busy_d[claim_addr_i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign any_busy_o = any_busy_q;

endmodule : rf_busy_table

`default_nettype wire

// File: rtl/mips_regfile_sb.sv
// =============================================================================
//  Module   : mips_regfile_sb
//  Brief    : Multi-read-port register file with zero register and busy
//             scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mips_regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  input  logic                    flush,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic                    any_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_valid;

  assign wr_valid = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (wr_valid) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  rf_busy_table #(
    .ADDR_W (ADDR_W)
  ) u_busy (
    .clk          (clk),
    .rst          (rst),
    .claim_en_i   (claim_en),
    .claim_addr_i (claim_addr),
    .rel_en_i     (wr_en),
    .rel_addr_i   (wr_addr),
    .flush_i      (flush),
    .busy_o       (busy),
    .any_busy_o   (any_busy)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;

    assign addr   = rd_addr[i*ADDR_W +: ADDR_W];
    assign stored = (addr == ADDR_W'(REG_ZERO)) ? '0 : mem_q[addr];

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_valid && (addr == wr_addr);
    assign rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : stored;
    assign rd_busy[i]                  = busy[addr] & ~hit;
`else
    assign rd_data[i*DATA_W +: DATA_W] = stored;
    assign rd_busy[i]                  = busy[addr];
`endif
  end

endmodule : mips_regfile_sb

`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
// =============================================================================
//  Module   : tb_mips_regfile_sb
//  Brief    : Directed self-checking bench for mips_regfile_sb (NREAD=2).
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mips_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        any_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_regfile_sb #(
    .DATA_W (32),
    .ADDR_W (5),
    .NREAD  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .any_busy   (any_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; claim_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wr_addr = '0; wr_data = '0; claim_addr = '0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
        failures++;
        $display("FAIL reset_read idx=%0d data=%h busy=%b expected data=0 busy=00", i, rd_data, rd_busy);
      end
    end
    checks++;
    if (any_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_any_busy got=%b expected=0", any_busy);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
`else
    if (rd_data[31:0] !== 32'h0) begin
`endif
      failures++;
      $display("FAIL write_cycle_r5 got=%h", rd_data[31:0]);
    end
    tick();
    idle(); rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL read_r5_both got=%h expected=deadbeefdeadbeef", rd_data);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr = {5'd5, 5'd0};
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'h0}) begin
      failures++;
      $display("FAIL write_r0_discard got=%h expected=deadbeef00000000", rd_data);
    end
  endtask

  task automatic test_claim_release();
    claim_en = 1'b1; claim_addr = 5'd7; rd_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL claim_cycle_busy got=%b expected=0", rd_busy[0]);
    end
    tick();                       // n+1
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || any_busy !== 1'b1) begin
      failures++;
      $display("FAIL claim_n1 busy=%b any=%b expected 1 1", rd_busy[0], any_busy);
    end
    tick();                       // n+2
    tick();                       // n+3: writeback
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL release_cycle busy=%b data=%h expected 0 a5a5a5a5", rd_busy[0], rd_data[31:0]);
    end
`else
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL release_cycle busy=%b data=%h expected 1 00000000", rd_busy[0], rd_data[31:0]);
    end
`endif
    tick();                       // n+4
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5 || any_busy !== 1'b0) begin
      failures++;
      $display("FAIL release_n4 busy=%b data=%h any=%b expected 0 a5a5a5a5 0", rd_busy[0], rd_data[31:0], any_busy);
    end
  endtask

  task automatic test_claim_write_same();
    claim_en = 1'b1; claim_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    rd_addr = {5'd9, 5'd9};
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== {32'h1, 32'h1} || rd_busy !== 2'b11 || any_busy !== 1'b1) begin
      failures++;
      $display("FAIL claim_write_same data=%h busy=%b any=%b expected 0000000100000001 11 1", rd_data, rd_busy, any_busy);
    end
  endtask

  task automatic test_flush();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    idle();
    claim_en = 1'b1; claim_addr = 5'd3; tick();
    claim_addr = 5'd4; tick();
    claim_addr = 5'd6; tick();
    idle();
    rd_addr = {5'd4, 5'd3};
    #1;
    checks++;
    if (rd_busy !== 2'b11 || any_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_flush busy=%b any=%b expected 11 1", rd_busy, any_busy);
    end
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCC;
    tick();
    idle();
    #1;
    checks++;
    if (any_busy !== 1'b0 || rd_busy !== 2'b00 || rd_data[31:0] !== 32'h33) begin
      failures++;
      $display("FAIL flush_r3r4 any=%b busy=%b r3=%h expected 0 00 00000033", any_busy, rd_busy, rd_data[31:0]);
    end
    rd_addr = {5'd8, 5'd6};
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++;
      $display("FAIL flush_r6r8 busy=%b expected 00", rd_busy);
    end
    rd_addr = {5'd9, 5'd12};
    #1;
    checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'hCC) begin
      failures++;
      $display("FAIL flush_r9_r12 busy=%b r12=%h expected 00 000000cc", rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55; claim_en = 1'b1; claim_addr = 5'd11;
    tick();
    idle();
    rd_addr = {5'd11, 5'd10};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h55 || rd_busy[1] !== 1'b1 || any_busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset r10=%h busy11=%b any=%b expected 00000055 1 1", rd_data[31:0], rd_busy[1], any_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[1] !== 1'b0 || any_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset r10=%h busy11=%b any=%b expected 00000000 0 0", rd_data[31:0], rd_busy[1], any_busy);
    end
    tick();
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h77; rd_addr = {5'd0, 5'd13};
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h77) begin
      failures++;
      $display("FAIL release_cycle_write r13=%h expected 00000077", rd_data[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_claim_release();
    test_claim_write_same();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mips_regfile_sb

`default_nettype wire
